// File: rtl/qmux_pkg.sv
// rtl/qmux_pkg.sv - shared types and constants for the QMUX select controller
package qmux_pkg;

  localparam int CNT_W = 8;

  localparam logic SRC_GMUX  = 1'b0;
  localparam logic SRC_QHSCK = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OFF = 2'd1,
    WAIT_ON  = 2'd2
  } qmux_state_e;

endpackage

// File: rtl/qmux_quiet_cnt.sv
// rtl/qmux_quiet_cnt.sv - loadable down-counter timing the quiet windows
module qmux_quiet_cnt
  import qmux_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at zero so a stray decrement can never wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/qmux_sel_ctrl.sv
// rtl/qmux_sel_ctrl.sv - glitch-free QMUX source switch: gate off, flip IS, gate on
module qmux_sel_ctrl
  import qmux_pkg::*;
#(
  parameter int QUIET_CYC = 4
) (
  input  logic QCK,
  input  logic QRT,
  input  logic REQ_VLD,
  input  logic REQ_SEL,
  output logic REQ_RDY,
  output logic IS,
  output logic GATE_EN,
  output logic BUSY,
  output logic DONE
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(QUIET_CYC - 1);

  qmux_state_e state_q, state_d;
  logic        is_q, is_d;
  logic        gate_q, gate_d;
  logic        done_q, done_d;
  logic        sel_q, sel_d;
  logic        pend_q, pend_d;
  logic        cnt_load, cnt_dec, cnt_zero;

  qmux_quiet_cnt u_cnt (
    .clk_i      (QCK),
    .rst_i      (QRT),
    .load_i     (cnt_load),
    .load_val_i (RELOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    is_d     = is_q;
    gate_d   = gate_q;
    sel_d    = sel_q;
    pend_d   = 1'b0;
    done_d   = pend_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A same-source request completes without touching the clock path.
        if (REQ_VLD) begin
          if (REQ_SEL == is_q) begin
            pend_d = 1'b1;
          end else begin
            sel_d    = REQ_SEL;
            gate_d   = 1'b0;
            cnt_load = 1'b1;
            state_d  = WAIT_OFF;
          end
        end
      end
      WAIT_OFF: begin
        if (cnt_zero) begin
          is_d     = sel_q;
          cnt_load = 1'b1;
          state_d  = WAIT_ON;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WAIT_ON: begin
        if (cnt_zero) begin
          gate_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      state_q <= IDLE;
      is_q    <= SRC_GMUX;
      gate_q  <= 1'b1;
      done_q  <= 1'b0;
      sel_q   <= SRC_GMUX;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      is_q    <= is_d;
      gate_q  <= gate_d;
      done_q  <= done_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
    end
  end

  assign REQ_RDY = (state_q == IDLE);
  assign BUSY    = ~REQ_RDY;
  assign IS      = is_q;
  assign GATE_EN = gate_q;
  assign DONE    = done_q;

endmodule

// File: tb/tb_qmux_sel_ctrl.sv
// tb/tb_qmux_sel_ctrl.sv - random and directed checks of two controller instances (QUIET_CYC 4 and 1)
module tb_qmux_sel_ctrl;

  localparam int NE = 8192;

  logic       QCK;
  logic       QRT;
  logic [1:0] vld, sel;
  logic [1:0] rdy, is_o, gate, busy, done;

  int n_chk  = 0;
  int n_pass = 0;
  int eidx   = 0;

  int q_cyc [2] = '{4, 1};
  bit m_busy [2];
  bit m_is   [2];
  bit m_tgt  [2];
  int m_start[2];
  bit done_sched[2][NE];

  qmux_sel_ctrl #(.QUIET_CYC(4)) dut4 (
    .QCK(QCK), .QRT(QRT), .REQ_VLD(vld[0]), .REQ_SEL(sel[0]), .REQ_RDY(rdy[0]),
    .IS(is_o[0]), .GATE_EN(gate[0]), .BUSY(busy[0]), .DONE(done[0])
  );

  qmux_sel_ctrl #(.QUIET_CYC(1)) dut1 (
    .QCK(QCK), .QRT(QRT), .REQ_VLD(vld[1]), .REQ_SEL(sel[1]), .REQ_RDY(rdy[1]),
    .IS(is_o[1]), .GATE_EN(gate[1]), .BUSY(busy[1]), .DONE(done[1])
  );

  initial QCK = 1'b0;
  always #5 QCK = ~QCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, eidx, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0;
      m_is[i]   = 1'b0;
      m_tgt[i]  = 1'b0;
      for (int k = 0; k < NE; k++) done_sched[i][k] = 1'b0;
    end
  endtask

  // Outcome of edge e, timed purely from the accept edge of a switch.
  task automatic model_edge(input int i, input int e);
    int el;
    if (m_busy[i]) begin
      el = e - m_start[i];
      if (el == q_cyc[i]) m_is[i] = m_tgt[i];
      if (el == 2 * q_cyc[i]) begin
        m_busy[i] = 1'b0;
        done_sched[i][e] = 1'b1;
      end
    end else if (vld[i]) begin
      if (sel[i] == m_is[i]) begin
        done_sched[i][e + 1] = 1'b1;
      end else begin
        m_busy[i]  = 1'b1;
        m_start[i] = e;
        m_tgt[i]   = sel[i];
      end
    end
  endtask

  task automatic check_all(input string pfx);
    for (int i = 0; i < 2; i++) begin
      check({pfx, (i == 0) ? "_q4_rdy"  : "_q1_rdy"},  32'(rdy[i]),  32'(!m_busy[i]));
      check({pfx, (i == 0) ? "_q4_busy" : "_q1_busy"}, 32'(busy[i]), 32'(m_busy[i]));
      check({pfx, (i == 0) ? "_q4_is"   : "_q1_is"},   32'(is_o[i]), 32'(m_is[i]));
      check({pfx, (i == 0) ? "_q4_gate" : "_q1_gate"}, 32'(gate[i]), 32'(!m_busy[i]));
      check({pfx, (i == 0) ? "_q4_done" : "_q1_done"}, 32'(done[i]), 32'(done_sched[i][eidx]));
    end
  endtask

  task automatic step(input logic v0, input logic s0, input logic v1, input logic s1);
    vld = {v1, v0};
    sel = {s1, s0};
    @(posedge QCK);
    eidx++;
    model_edge(0, eidx);
    model_edge(1, eidx);
    #1;
    vld = 2'b00;
    check_all("step");
  endtask

  // Reset lands mid-cycle so the check sees the asynchronous effect alone.
  task automatic async_reset();
    #2;
    QRT = 1'b1;
    #1;
    model_reset();
    check_all("arst");
    @(posedge QCK);
    eidx++;
    #1;
    QRT = 1'b0;
  endtask

  initial begin
    QRT = 1'b1;
    vld = 2'b00;
    sel = 2'b00;
    model_reset();
    repeat (2) @(posedge QCK);
    eidx = 2;
    #1;
    check_all("reset");
    QRT = 1'b0;

    // same source on both instances
    step(1'b1, qmux_pkg::SRC_GMUX, 1'b1, qmux_pkg::SRC_GMUX);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // switch to QHSCK on q4 with an ignored request at edge 2
    step(1'b1, qmux_pkg::SRC_QHSCK, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, qmux_pkg::SRC_GMUX, 1'b0, 1'b0);
    repeat (9) step(1'b0, 1'b0, 1'b0, 1'b0);

    // reset at edge 5 of a switch back to GMUX... and then to QHSCK after reset
    step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
    async_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (9) step(1'b0, 1'b0, 1'b0, 1'b0);

    // q1 back-to-back: second request issued while DONE is high
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("b2b_done_cycle", 32'(done[1]), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("b2b_is_back", 32'(is_o[1]), 32'd0);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
